// File: rtl/svreal_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point (svreal) multiplier among N_REQ clients.
// Define SVREAL_MUL_SAT_EN to saturate out-of-range results; otherwise they wrap.
module svreal_mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int A_WIDTH     = 16,
  parameter int A_EXP       = -8,
  parameter int B_WIDTH     = 16,
  parameter int B_EXP       = -8,
  parameter int C_WIDTH     = 16,
  parameter int C_EXP       = -8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ*A_WIDTH-1:0]          req_a,
  input  logic [N_REQ*B_WIDTH-1:0]          req_b,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(N_REQ)-1:0]          rsp_id,
  output logic signed [C_WIDTH-1:0]         rsp_c,
  output logic [$clog2(PIPE_STAGES+1):0]    busy,
  output logic                              ovf
);

  localparam int IW     = $clog2(N_REQ);
  localparam int PW     = A_WIDTH + B_WIDTH;
  localparam int LSHIFT = A_EXP + B_EXP - C_EXP;
  localparam int LSH    = (LSHIFT > 0) ? LSHIFT : 0;
  localparam int RSH    = (LSHIFT < 0) ? -LSHIFT : 0;
  localparam int AW     = PW + LSH;
  localparam int XW     = ((AW > C_WIDTH) ? AW : C_WIDTH) + 1;
  localparam int LAST   = PIPE_STAGES - 1;
  localparam int BW     = $clog2(PIPE_STAGES + 1) + 1;

  function automatic logic signed [XW-1:0] align(input logic signed [PW-1:0] p);
    logic signed [XW-1:0] x;
    x = XW'(p);
    return (x <<< LSH) >>> RSH;
  endfunction

  // Out of range when the bits above the C sign bit are not a pure sign extension.
  function automatic logic out_of_range(input logic signed [XW-1:0] v);
    logic [XW-C_WIDTH:0] hi;
    hi = v[XW-1:C_WIDTH-1];
    return !((&hi) || !(|hi));
  endfunction

  function automatic logic signed [C_WIDTH-1:0] fit(input logic signed [XW-1:0] v);
    logic signed [C_WIDTH-1:0] r;
    r = C_WIDTH'(v);
`ifdef SVREAL_MUL_SAT_EN
    if (out_of_range(v)) begin
      r = v[XW-1] ? {1'b1, {(C_WIDTH-1){1'b0}}} : {1'b0, {(C_WIDTH-1){1'b1}}};
    end
`endif
    return r;
  endfunction

  logic                     vld_q  [PIPE_STAGES];
  logic [IW-1:0]            id_q   [PIPE_STAGES];
  logic signed [PW-1:0]     prod_q [PIPE_STAGES];
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [BW-1:0]            busy_q, busy_d;
  logic                     ovf_q, ovf_d;

  logic [N_REQ-1:0]         gnt;
  logic [IW-1:0]            gidx;
  logic                     found;
  int                       idx;
  logic signed [A_WIDTH-1:0] a_sel;
  logic signed [B_WIDTH-1:0] b_sel;
  logic signed [PW-1:0]     prod;
  logic signed [XW-1:0]     aligned;
  logic                     stall, accept, rsp_done;

  // Cyclic priority search starting at the round-robin pointer.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gidx     = IW'(idx);
      end
    end
  end

  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = gnt & {N_REQ{rst_n && !stall}};
  assign accept    = |(req_valid & req_ready);
  assign rsp_done  = rsp_valid && rsp_ready;

  assign a_sel = req_a[gidx*A_WIDTH +: A_WIDTH];
  assign b_sel = req_b[gidx*B_WIDTH +: B_WIDTH];
  assign prod  = PW'(a_sel) * PW'(b_sel);

  assign aligned   = align(prod_q[LAST]);
  assign rsp_valid = vld_q[LAST];
  assign rsp_id    = id_q[LAST];
  assign rsp_c     = fit(aligned);
  assign busy      = busy_q;
  assign ovf       = ovf_q;

  always_comb begin
    ptr_d  = ptr_q;
    busy_d = busy_q;
    ovf_d  = ovf_q | (vld_q[LAST] & out_of_range(aligned));
    if (accept) ptr_d = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    if (accept && !rsp_done)      busy_d = busy_q + BW'(1);
    else if (!accept && rsp_done) busy_d = busy_q - BW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        vld_q[s]  <= 1'b0;
        id_q[s]   <= '0;
        prod_q[s] <= '0;
      end
      ptr_q  <= '0;
      busy_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // Stage 0 captures the raw product; later stages only carry it forward.
      if (!stall) begin
        vld_q[0]  <= accept;
        id_q[0]   <= gidx;
        prod_q[0] <= prod;
        for (int s = 1; s < PIPE_STAGES; s++) begin
          vld_q[s]  <= vld_q[s-1];
          id_q[s]   <= id_q[s-1];
          prod_q[s] <= prod_q[s-1];
        end
      end
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_svreal_mul_arbiter.sv
// Scoreboard bench for svreal_mul_arbiter: acceptances push expected results, a monitor pops them.
module tb_svreal_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [3:0]         req_valid, req_ready;
  logic [63:0]        req_a, req_b;
  logic               rsp_valid, rsp_ready;
  logic [1:0]         rsp_id;
  logic signed [15:0] rsp_c;
  logic [2:0]         busy;
  logic               ovf;

  logic [3:0]         req_valid2, req_ready2;
  logic [63:0]        req_a2, req_b2;
  logic               rsp_valid2, rsp_ready2;
  logic [1:0]         rsp_id2;
  logic signed [15:0] rsp_c2;
  logic [2:0]         busy2;
  logic               ovf2;

  svreal_mul_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy), .ovf(ovf)
  );

  svreal_mul_arbiter #(.C_EXP(-4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_id(rsp_id2), .rsp_c(rsp_c2), .busy(busy2), .ovf(ovf2)
  );

`ifdef SVREAL_MUL_SAT_EN
  localparam int EXP_POS = 32767;
  localparam int EXP_NEG = -32768;
`else
  localparam int EXP_POS = -14336;
  localparam int EXP_NEG = 14336;
`endif

  typedef struct packed {
    logic [1:0]         id;
    logic signed [15:0] c;
  } exp_t;

  exp_t               sbq[$];
  int                 acc_q[$];
  logic signed [15:0] expc [4];
  int                 n_chk = 0;
  int                 n_fail = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Acceptance monitor: the handshake seen at this negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sbq.push_back('{id: 2'(i), c: expc[i]});
          acc_q.push_back(i);
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp_id", rsp_id, -1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_c", rsp_c, e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input int c);
    req_a[i*16 +: 16] = 16'(a);
    req_b[i*16 +: 16] = 16'(b);
    expc[i]           = 16'(c);
    req_valid[i]      = 1'b1;
  endtask

  task automatic send(input int i, input int a, input int b, input int c);
    logic ok;
    ok = 1'b0;
    set_req(i, a, b, c);
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
    end
    tick();
    req_valid[i] = 1'b0;
    chk("accept_wait", ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic got;
    rst_n = 1'b0; req_valid = 4'b0101; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid2 = '0; req_a2 = '0; req_b2 = '0; rsp_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) expc[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_req_ready", req_ready, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single multiply with latency check
    send(2, 384, -512, -768);
    @(negedge clk); chk("lat_cycle1_valid", rsp_valid, 0); chk("busy_one", busy, 1);
    @(negedge clk); chk("lat_cycle2_valid", rsp_valid, 1);
    @(negedge clk); chk("single_ovf", ovf, 0); chk("single_busy_idle", busy, 0);

    // Round-robin with all requesters held for 8 cycles
    rst_n = 1'b0; #1; rst_n = 1'b1;
    sbq.delete(); acc_q.delete();
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 128 * (i + 1), -256 * (i + 1), -128 * (i + 1) * (i + 1));
    repeat (8) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("rr_count", acc_q.size(), 8);
    for (int k = 0; k < acc_q.size(); k++) chk("rr_order", acc_q[k], k % 4);
    chk("rr_drain", sbq.size(), 0);

    // Backpressure: three back-to-back requests, 3 stalled cycles on the first result
    set_req(0, 512, 512, 1024);
    set_req(1, -128, 768, -384);
    set_req(2, 64, 64, 16);
    tick(); req_valid[0] = 1'b0;
    tick(); req_valid[1] = 1'b0; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 0);
      chk("stall_c_held", rsp_c, 1024);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_busy", busy, 2);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk); chk("post_stall_grant", req_ready, 4'b0100);
    tick(); req_valid[2] = 1'b0;
    repeat (5) tick();
    chk("bp_busy_zero", busy, 0);
    chk("bp_drain", sbq.size(), 0);

    // Range boundaries and floor rounding, no overflow expected
    send(0, 32767, 256, 32767);
    send(1, -32768, 256, -32768);
    send(2, 1, -1, -1);
    repeat (4) tick();
    chk("bound_ovf_clear", ovf, 0);

    // Overflow, both signs, then sticky behaviour
    send(3, 25600, 512, EXP_POS);
    repeat (4) tick();
    chk("ovf_set", ovf, 1);
    send(0, -25600, 512, EXP_NEG);
    send(1, 256, 256, 256);
    repeat (4) tick();
    chk("ovf_sticky", ovf, 1);
    chk("ovf_drain", sbq.size(), 0);

    // Exponent realignment with C_EXP=-4
    req_a2[15:0] = 16'd384; req_b2[15:0] = 16'(-512); req_valid2 = 4'b0001;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (req_ready2[0]) got = 1'b1;
    end
    tick(); req_valid2 = '0;
    chk("c4_accept_wait", got, 1);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid2) got = 1'b1;
    end
    chk("c4_rsp_wait", got, 1);
    chk("c4_rsp_c", rsp_c2, -48);
    chk("c4_rsp_id", rsp_id2, 0);
    tick();
    chk("c4_busy", busy2, 0);
    chk("c4_ovf", ovf2, 0);

    // Reset with two operations in flight
    set_req(1, 256, 256, 256);
    set_req(3, -256, 256, -256);
    tick();
    tick();
    rst_n = 1'b0;
    sbq.delete(); acc_q.delete();
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_c", rsp_c, 0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk); chk("midrst_first_grant", req_ready, 4'b0010);
    tick(); req_valid[1] = 1'b0;
    @(negedge clk); chk("midrst_second_grant", req_ready, 4'b1000);
    tick(); req_valid[3] = 1'b0;
    repeat (5) tick();
    chk("midrst_busy_idle", busy, 0);
    chk("midrst_drain", sbq.size(), 0);
    chk("midrst_acc_count", acc_q.size(), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
